// File: rtl/adc_spi_master.sv
// SPI master for an external 10-bit ADC: one cs_n-framed mode-0 transaction per accepted adc_go.
// adc_valid pulses CLK_DIV*(2*FRAME_BITS+2) cycles after the accepting edge; adc_go is ignored while adc_busy.
module adc_spi_master #(
  parameter int CLK_DIV    = 2,
  parameter int FRAME_BITS = 16,
  parameter int DATA_LSB   = 0,
  parameter int T_CSH      = 8
) (
  input  logic       clk3p2M,
  input  logic       reset,
  input  logic       adc_go,
  input  logic [3:0] adc_chan,
  output logic [9:0] adc_in,
  output logic       adc_valid,
  output logic       adc_busy,
  output logic       adc_sclk,
  output logic       adc_cs_n,
  output logic       adc_mosi,
  input  logic       adc_miso
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int HP_W  = $clog2(2 * FRAME_BITS);
  localparam int GAP_W = (T_CSH > 2) ? $clog2(T_CSH - 1) : 1;
  localparam int RX_W  = DATA_LSB + 10;
  localparam int TX_W  = FRAME_BITS - 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [HP_W-1:0]  HP_LAST  = HP_W'(2 * FRAME_BITS - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(T_CSH - 2);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, DONE, GAP} state_t;

  state_t            state_q, state_d;
  logic [TX_W-1:0]   tx_q, tx_d;
  logic [RX_W-1:0]   rx_q, rx_d;
  logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
  logic [HP_W-1:0]   hp_cnt_q, hp_cnt_d;
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic              sclk_q, sclk_d;
  logic              cs_n_q, cs_n_d;
  logic              mosi_q, mosi_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic [9:0]        data_q, data_d;

  always_comb begin
    state_d   = state_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    div_cnt_d = div_cnt_q;
    hp_cnt_d  = hp_cnt_q;
    gap_cnt_d = gap_cnt_q;
    sclk_d    = sclk_q;
    cs_n_d    = cs_n_q;
    mosi_d    = mosi_q;
    valid_d   = 1'b0;
    busy_d    = busy_q;
    data_d    = data_q;

    case (state_q)
      IDLE: begin
        if (adc_go) begin
          // tx holds only the bits still to be sent; the channel MSB goes straight to mosi
          tx_d      = {adc_chan[2:0], {(FRAME_BITS-4){1'b0}}};
          mosi_d    = adc_chan[3];
          rx_d      = '0;
          div_cnt_d = '0;
          hp_cnt_d  = '0;
          cs_n_d    = 1'b0;
          busy_d    = 1'b1;
          state_d   = SETUP;
        end
      end
      SETUP: begin
        if (div_cnt_q == DIV_LAST) begin
          div_cnt_d = '0;
          sclk_d    = 1'b1;
          rx_d      = {rx_q[RX_W-2:0], adc_miso};
          state_d   = SHIFT;
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end
      SHIFT: begin
        if (div_cnt_q == DIV_LAST) begin
          div_cnt_d = '0;
          if (hp_cnt_q == HP_LAST) begin
            mosi_d  = 1'b0;
            state_d = HOLD;
          end else begin
            hp_cnt_d = hp_cnt_q + 1'b1;
            if (!sclk_q) begin
              sclk_d = 1'b1;
              rx_d   = {rx_q[RX_W-2:0], adc_miso};
            end else begin
              sclk_d = 1'b0;
              mosi_d = tx_q[TX_W-1];
              tx_d   = {tx_q[TX_W-2:0], 1'b0};
            end
          end
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end
      HOLD: begin
        if (div_cnt_q == DIV_LAST) begin
          div_cnt_d = '0;
          cs_n_d    = 1'b1;
          mosi_d    = 1'b0;
          valid_d   = 1'b1;
          data_d    = rx_q[RX_W-1:DATA_LSB];
          state_d   = DONE;
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end
      DONE: begin
        // DONE is the first cs_n-high cycle, so GAP supplies the remaining T_CSH-1
        if (T_CSH > 1) begin
          gap_cnt_d = '0;
          state_d   = GAP;
        end else begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk3p2M) begin
    if (reset) begin
      state_q   <= IDLE;
      tx_q      <= '0;
      rx_q      <= '0;
      div_cnt_q <= '0;
      hp_cnt_q  <= '0;
      gap_cnt_q <= '0;
      sclk_q    <= 1'b0;
      cs_n_q    <= 1'b1;
      mosi_q    <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      div_cnt_q <= div_cnt_d;
      hp_cnt_q  <= hp_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      sclk_q    <= sclk_d;
      cs_n_q    <= cs_n_d;
      mosi_q    <= mosi_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      data_q    <= data_d;
    end
  end

  assign adc_in    = data_q;
  assign adc_valid = valid_q;
  assign adc_busy  = busy_q;
  assign adc_sclk  = sclk_q;
  assign adc_cs_n  = cs_n_q;
  assign adc_mosi  = mosi_q;

endmodule

// File: tb/tb_adc_spi_master.sv
// Bench for adc_spi_master: instance a uses defaults, instance b uses CLK_DIV=1, DATA_LSB=2.
// A behavioural SPI slave per instance serves queued response words; a monitor scores every adc_valid.
module tb_adc_spi_master;

  localparam int LAT_A = 2 * (2 * 16 + 2);
  localparam int LAT_B = 1 * (2 * 16 + 2);
  localparam int LSB_A = 0;
  localparam int LSB_B = 2;
  localparam int TCSH  = 8;

  typedef struct {
    int          inst;
    logic [15:0] resp;
  } resp_t;

  typedef struct {
    int          inst;
    logic [3:0]  chan;
    logic [9:0]  sample;
  } exp_t;

  logic clk;
  logic reset;
  logic go_a, go_b;
  logic [3:0] chan_a, chan_b;
  logic [9:0] in_a, in_b;
  logic val_a, val_b, busy_a, busy_b, sclk_a, sclk_b, cs_a, cs_b, mosi_a, mosi_b;
  logic [1:0] miso_v;

  logic [1:0] val_v, busy_v, sclk_v, cs_v, mosi_v;
  logic [1:0][9:0] in_v;
  assign val_v  = {val_b, val_a};
  assign busy_v = {busy_b, busy_a};
  assign sclk_v = {sclk_b, sclk_a};
  assign cs_v   = {cs_b, cs_a};
  assign mosi_v = {mosi_b, mosi_a};
  assign in_v   = {in_b, in_a};

  adc_spi_master dut_a (
    .clk3p2M(clk), .reset(reset), .adc_go(go_a), .adc_chan(chan_a),
    .adc_in(in_a), .adc_valid(val_a), .adc_busy(busy_a), .adc_sclk(sclk_a),
    .adc_cs_n(cs_a), .adc_mosi(mosi_a), .adc_miso(miso_v[0])
  );

  adc_spi_master #(.CLK_DIV(1), .FRAME_BITS(16), .DATA_LSB(2), .T_CSH(8)) dut_b (
    .clk3p2M(clk), .reset(reset), .adc_go(go_b), .adc_chan(chan_b),
    .adc_in(in_b), .adc_valid(val_b), .adc_busy(busy_b), .adc_sclk(sclk_b),
    .adc_cs_n(cs_b), .adc_mosi(mosi_b), .adc_miso(miso_v[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;
  bit b2b = 1'b0;
  resp_t resp_q[$];
  exp_t  exp_q[$];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: the sample is the 10-bit field of the response word starting at the instance's LSB.
  task automatic push_frame(int i, logic [3:0] ch, logic [15:0] r, bit expect_valid);
    resp_t rr;
    exp_t  ee;
    int    rv;
    int    lsb;
    rv  = r;
    lsb = (i == 0) ? LSB_A : LSB_B;
    rr.inst = i;
    rr.resp = r;
    resp_q.push_back(rr);
    if (expect_valid) begin
      ee.inst   = i;
      ee.chan   = ch;
      ee.sample = 10'((rv / (1 << lsb)) % 1024);
      exp_q.push_back(ee);
    end
  endtask

  // Slave model and scoreboard monitor, both evaluated on the falling clock edge.
  logic [15:0] sh [2];
  logic [15:0] cmd [2];
  int cnt [2];
  int fall_cyc [2];
  int rise_cyc [2];
  int valid_cyc [2];
  logic [1:0] prev_cs, prev_sclk, prev_busy;

  initial begin
    resp_t r;
    exp_t  e;
    miso_v    = 2'b00;
    prev_cs   = 2'b11;
    prev_sclk = 2'b00;
    prev_busy = 2'b00;
    for (int i = 0; i < 2; i++) begin
      sh[i] = '0; cmd[i] = '0; cnt[i] = 0;
      fall_cyc[i] = 0; rise_cyc[i] = -1; valid_cyc[i] = -1;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (prev_cs[i] && !cs_v[i]) begin
          fall_cyc[i] = cyc;
          if (b2b && i == 0 && rise_cyc[i] >= 0)
            check("cs_gap_b2b", cyc - rise_cyc[i], TCSH + 1);
          check("frame_has_resp", resp_q.size() > 0, 1);
          sh[i] = '0;
          if (resp_q.size() > 0) begin
            r = resp_q.pop_front();
            check("resp_inst", r.inst, i);
            sh[i] = r.resp;
          end
          miso_v[i] = sh[i][15];
          cmd[i] = '0;
          cnt[i] = 0;
        end else if (!cs_v[i]) begin
          if (!prev_sclk[i] && sclk_v[i]) begin
            cmd[i] = {cmd[i][14:0], mosi_v[i]};
            cnt[i]++;
          end
          if (prev_sclk[i] && !sclk_v[i]) begin
            sh[i] = {sh[i][14:0], 1'b0};
            miso_v[i] = sh[i][15];
          end
        end
        if (!prev_cs[i] && cs_v[i]) rise_cyc[i] = cyc;
        if (cs_v[i]) check("idle_sclk_mosi", {sclk_v[i], mosi_v[i]}, 2'b00);

        if (val_v[i]) begin
          check("valid_expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("valid_inst", i, e.inst);
            check("adc_in", in_v[i], e.sample);
            check("mosi_cmd", cmd[i], {e.chan, 12'h000});
            check("sclk_pulses", cnt[i], 16);
            check("valid_latency", cyc - fall_cyc[i], (i == 0) ? LAT_A : LAT_B);
            check("busy_at_valid", busy_v[i], 1);
          end
          valid_cyc[i] = cyc;
        end
        if (prev_busy[i] && !busy_v[i]) begin
          if (valid_cyc[i] >= 0) check("busy_release", cyc - valid_cyc[i], TCSH);
          valid_cyc[i] = -1;
        end
      end
      prev_cs   = cs_v;
      prev_sclk = sclk_v;
      prev_busy = busy_v;
    end
  end

  task automatic wait_idle(int i);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy_v[i] && n < 400);
    check("idle_within_budget", busy_v[i], 0);
  endtask

  task automatic wait_valid(int i);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!val_v[i] && n < 400);
    check("valid_within_budget", val_v[i], 1);
  endtask

  // Called at a falling edge while idle; the next rising edge accepts the request.
  task automatic pulse_go(int i, logic [3:0] ch);
    if (i == 0) begin go_a = 1'b1; chan_a = ch; end
    else        begin go_b = 1'b1; chan_b = ch; end
    @(negedge clk);
    go_a = 1'b0;
    go_b = 1'b0;
  endtask

  initial begin
    logic [3:0]  ch;
    logic [15:0] r;
    reset  = 1'b1;
    go_a   = 1'b1;
    chan_a = 4'd5;
    go_b   = 1'b0;
    chan_b = 4'd0;

    // Reset held with go asserted; the first post-reset edge starts the frame.
    push_frame(0, 4'd5, 16'h02A5, 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cs_n", cs_v, 2'b11);
    check("rst_sclk", sclk_v, 2'b00);
    check("rst_mosi", mosi_v, 2'b00);
    check("rst_valid", val_v, 2'b00);
    check("rst_busy", busy_v, 2'b00);
    check("rst_adc_in_a", in_a, 10'h000);
    check("rst_adc_in_b", in_b, 10'h000);
    reset = 1'b0;
    @(negedge clk);
    check("first_frame_busy", busy_a, 1'b1);
    check("first_frame_cs_n", cs_a, 1'b0);
    go_a = 1'b0;
    wait_idle(0);

    // Second request while busy must be dropped.
    push_frame(0, 4'd3, 16'($urandom), 1'b1);
    pulse_go(0, 4'd3);
    repeat (19) @(negedge clk);
    pulse_go(0, 4'd9);
    wait_idle(0);

    for (int k = 0; k < 6; k++) begin
      repeat ($urandom_range(0, 4)) @(negedge clk);
      ch = 4'($urandom);
      r  = 16'($urandom);
      push_frame(0, ch, r, 1'b1);
      pulse_go(0, ch);
      wait_idle(0);
    end

    // Back-to-back with go held high, channel advanced after each sample.
    push_frame(0, 4'd0, 16'($urandom), 1'b1);
    chan_a = 4'd0;
    go_a   = 1'b1;
    for (int k = 0; k < 17; k++) begin
      wait_valid(0);
      b2b = 1'b1;
      if (k < 16) begin
        ch = 4'((k + 1) % 16);
        chan_a = ch;
        push_frame(0, ch, 16'($urandom), 1'b1);
      end else begin
        go_a = 1'b0;
      end
    end
    wait_idle(0);
    b2b = 1'b0;

    // Reset in the middle of a frame.
    push_frame(0, 4'd7, 16'($urandom), 1'b0);
    go_a = 1'b1;
    chan_a = 4'd7;
    @(negedge clk);
    go_a = 1'b0;
    repeat (30) @(negedge clk);
    check("abort_cs_before_reset", cs_a, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    check("abort_cs_n", cs_a, 1'b1);
    check("abort_valid", val_a, 1'b0);
    check("abort_busy", busy_a, 1'b0);
    check("abort_adc_in", in_a, 10'h000);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_adc_in_held", in_a, 10'h000);
    push_frame(0, 4'd2, 16'h03FF, 1'b1);
    pulse_go(0, 4'd2);
    wait_idle(0);

    // Fast divider with offset data field.
    for (int k = 0; k < 4; k++) begin
      r  = (k == 0) ? 16'h0FFC : 16'($urandom);
      ch = 4'($urandom);
      push_frame(1, ch, r, 1'b1);
      pulse_go(1, ch);
      wait_idle(1);
    end

    repeat (5) @(negedge clk);
    check("exp_q_drained", exp_q.size(), 0);
    check("resp_q_drained", resp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
